// File: rtl/enet_rx_pkg.sv
// enet_rx_pkg
// Shared definitions for the GMII receive frame engine: FSM state encoding,
// preamble/SFD byte values and the Ethernet CRC32 constants (reflected form).
package enet_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_state_e;

  localparam logic [7:0]  ENET_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ENET_SFD         = 8'hD5;

  localparam logic [31:0] ENET_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ENET_CRC_INIT    = 32'hFFFFFFFF;
  // Register value left after running a good frame's FCS through the CRC.
  localparam logic [31:0] ENET_CRC_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/enet_crc32_d8.sv
// enet_crc32_d8
// Combinational one-byte step of the Ethernet CRC32 (reflected polynomial,
// data consumed LSB first, no inversion). Shared by RX check and TX FCS.
// Ports:
//   i_data  8-bit data byte
//   i_crc   current 32-bit CRC register
//   o_crc   CRC register after absorbing i_data
module enet_crc32_d8
  import enet_rx_pkg::*;
(
  input  logic [7:0]  i_data,
  input  logic [31:0] i_crc,
  output logic [31:0] o_crc
);

  always_comb begin
    logic [31:0] w_c;
    w_c = i_crc;
    for (int i = 0; i < 8; i++) begin
      w_c = (w_c >> 1) ^ ((w_c[0] ^ i_data[i]) ? ENET_CRC_POLY : 32'h0);
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/enet_gmii_rx_frame.sv
// enet_gmii_rx_frame
// GMII receive frame engine: strips preamble/SFD, checks CRC32, removes the
// 4-byte FCS through a 5-entry delay line and streams payload bytes on a
// non-stallable valid/last/user interface. Frame status pulses on
// frame_good / frame_bad in the cycle the frame ends.
// Ports:
//   clk, rst            gmii_rx_clk, synchronous active-high reset
//   gmii_rx_dv/er/rxd   GMII receive byte stream
//   m_valid/data/last   payload byte stream (no backpressure)
//   m_user              bad frame flag, qualified by m_last
//   frame_good/bad      one-cycle end-of-frame status pulses
//   link_up, link_speed, full_duplex
//                       RGMII in-band status, present only when
//                       ENET_RX_INBAND_STATUS_EN is defined
module enet_gmii_rx_frame
  import enet_rx_pkg::*;
#(
  parameter int MAX_FRAME_LEN = 1518,
  parameter int MIN_FRAME_LEN = 64,
  parameter bit CHECK_CRC     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [7:0] gmii_rxd,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       m_user,
  output logic       frame_good,
  output logic       frame_bad
`ifdef ENET_RX_INBAND_STATUS_EN
  ,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
`endif
);

  localparam logic [10:0] LP_MAX = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] LP_MIN = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] LP_DLY = 11'd5;

  rx_state_e        r_state;
  logic [31:0]      r_crc;
  logic [10:0]      r_cnt;
  logic             r_er;
  logic [4:0][7:0]  r_dly;   // [4] is the oldest byte once r_cnt >= 5
  logic [31:0]      w_crc_nxt;
  logic             w_eof_bad;

  enet_crc32_d8 u_crc (
    .i_data (gmii_rxd),
    .i_crc  (r_crc),
    .o_crc  (w_crc_nxt)
  );

  assign w_eof_bad = r_er | (r_cnt < LP_MIN) |
                     (CHECK_CRC & (r_crc != ENET_CRC_RESIDUE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_crc      <= ENET_CRC_INIT;
      r_cnt      <= '0;
      r_er       <= 1'b0;
      r_dly      <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      m_user     <= 1'b0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
    end else begin
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_user     <= 1'b0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (gmii_rx_dv)
            r_state <= (gmii_rxd == ENET_PREAMBLE) ? PRE : DROP;
        end
        PRE: begin
          if (!gmii_rx_dv) begin
            r_state <= IDLE;
          end else if (gmii_rxd == ENET_SFD) begin
            r_state <= DATA;
            r_crc   <= ENET_CRC_INIT;
            r_cnt   <= '0;
            r_er    <= 1'b0;
          end else if (gmii_rxd != ENET_PREAMBLE) begin
            r_state <= DROP;
          end
        end
        DATA: begin
          if (gmii_rx_dv) begin
            if (r_cnt == LP_MAX) begin
              // Byte beyond the maximum length: close the frame now on the
              // oldest buffered byte and discard the remainder.
              m_valid   <= 1'b1;
              m_data    <= r_dly[4];
              m_last    <= 1'b1;
              m_user    <= 1'b1;
              frame_bad <= 1'b1;
              r_state   <= DROP;
            end else begin
              r_crc <= w_crc_nxt;
              r_dly <= {r_dly[3:0], gmii_rxd};
              r_cnt <= r_cnt + 11'd1;
              if (gmii_rx_er) r_er <= 1'b1;
              if (r_cnt >= LP_DLY) begin
                m_valid <= 1'b1;
                m_data  <= r_dly[4];
              end
            end
          end else begin
            // The 4 newest delay-line bytes are the FCS and are dropped.
            if (r_cnt >= LP_DLY) begin
              m_valid    <= 1'b1;
              m_data     <= r_dly[4];
              m_last     <= 1'b1;
              m_user     <= w_eof_bad;
              frame_good <= ~w_eof_bad;
              frame_bad  <= w_eof_bad;
            end else begin
              frame_bad  <= 1'b1;
            end
            r_state <= IDLE;
          end
        end
        DROP: begin
          if (!gmii_rx_dv) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ENET_RX_INBAND_STATUS_EN
  // Between frames RGMII PHYs place link status on rxd[3:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      link_up     <= 1'b0;
      link_speed  <= 2'b00;
      full_duplex <= 1'b0;
    end else if (!gmii_rx_dv && !gmii_rx_er) begin
      link_up     <= gmii_rxd[0];
      link_speed  <= gmii_rxd[2:1];
      full_duplex <= gmii_rxd[3];
    end
  end
`endif

endmodule

// File: doc/enet_gmii_rx_frame.md
Name: enet_gmii_rx_frame

Overview:
Receive-side frame engine for the Ethernet MAC. It consumes the single-clock GMII byte stream produced by the RGMII receive capture: gmii_rx_dv is the rising-edge control, and gmii_rx_er is the falling-edge control XOR dv. It strips the preamble and SFD, checks the CRC32, removes the FCS, and presents payload bytes on a non-stallable valid/last/user stream to the MAC RX DMA.

Parameters:
MAX_FRAME_LEN, 1518, maximum byte count after SFD including FCS; longer frames are truncated and flagged.
MIN_FRAME_LEN, 64, minimum byte count including FCS; shorter frames are flagged as runt.
CHECK_CRC, 1, 1 = a CRC mismatch sets m_user; 0 = CRC is ignored.

Ports:
clk  in  1  gmii_rx_clk domain; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
gmii_rx_dv  in  1  GMII receive data valid.
gmii_rx_er  in  1  GMII receive error.
gmii_rxd  in  8  GMII receive byte.
m_valid  out  1  output byte valid, one-cycle qualifier; there is no ready.
m_data  out  8  payload byte (destination MAC through the last payload byte).
m_last  out  1  last payload byte of the frame.
m_user  out  1  bad frame; meaningful only when m_last=1.
frame_good  out  1  one-cycle pulse when a frame ends with no error.
frame_bad  out  1  one-cycle pulse when a frame ends with an error, or a sub-5-byte fragment is discarded.

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, the delay line is emptied, CRC = 0xFFFFFFFF. A reset mid-frame abandons the frame with no m_last; the FSM resumes in IDLE, and the rest of that frame is handled as DROP/IDLE.
- FSM states:
  - IDLE:
    - dv=1 and rxd=0x55 -> PRE.
    - dv=1 and any other byte -> DROP.
  - PRE:
    - dv=1 and rxd=0x55 -> stay.
    - dv=1 and rxd=0xD5 -> DATA, with CRC, byte count and error flag cleared.
    - dv=1 and any other byte -> DROP.
    - dv=0 -> IDLE; no pulse.
  - DATA:
    - Each dv=1 byte updates the CRC (reflected polynomial 0xEDB88320, LSB first).
    - The byte shifts into a 5-entry delay line and increments an 11-bit count.
    - While dv=1 with the delay line full, the oldest byte is emitted with m_valid=1 and m_last=0.
  - DROP: ignore input until dv=0, then go to IDLE. No output.
- Latency: payload byte n is emitted registered, one cycle after byte n+5 arrives.
- End of frame (DATA and dv=0), with count >= 5:
  - Emit the oldest delay-line byte with m_valid=1 and m_last=1.
  - m_user = er_seen | runt | trunc | (CHECK_CRC & crc_bad).
  - crc_bad means the CRC register is not equal to the residue 0xDEBB20E3.
  - runt means count < MIN_FRAME_LEN.
  - The remaining 4 FCS bytes are discarded.
  - In the same cycle, pulse frame_good if m_user=0, otherwise frame_bad.
  - Next state IDLE.
- End of frame with count < 5: no output, pulse frame_bad, next state IDLE.
- er in DATA: gmii_rx_er=1 while dv=1 sets er_seen, sticky for the frame. er with dv=0 (carrier extend / false carrier) is ignored.
- Truncation: when count reaches MAX_FRAME_LEN and dv is still 1, the current oldest byte is emitted as m_last with m_user=1 (trunc) and frame_bad pulses. The FSM then goes to DROP.
- Back-to-back frames: a dv=0 gap of at least 1 cycle is sufficient. The end-of-frame cycle and the next frame's first preamble byte may coincide; the FSM then goes directly IDLE-equivalent -> PRE.
- Consecutive m_valid: at most one per cycle. m_last is never asserted without m_valid.

Optional Feature:
ENET_RX_INBAND_STATUS_EN
- Defined:
  - Adds outputs link_up (1), link_speed (2; 00=10M, 01=100M, 10=1000M) and full_duplex (1). All are reset to 0.
  - They update from gmii_rxd[0], [2:1] and [3] on any cycle with dv=0 and er=0 (RGMII in-band status).
  - They hold their value during frames.
- Undefined: these ports and their logic are absent, and the inter-frame bytes are ignored.

Decomposition:
- Package enet_rx_pkg holds:
  - FSM state enum (IDLE, PRE, DATA, DROP).
  - ENET_PREAMBLE=8'h55 and ENET_SFD=8'hD5.
  - ENET_CRC_POLY=32'hEDB88320, ENET_CRC_INIT=32'hFFFFFFFF and ENET_CRC_RESIDUE=32'hDEBB20E3.
- One combinational sub-module, enet_crc32_d8: 8-bit data in, 32-bit CRC in, next 32-bit CRC out. It is shared with the future TX FCS generator.

Test Plan:
- 64-byte frame with valid FCS (7x55, D5, 60 payload bytes, 4 FCS) -> 60 m_valid beats, data identical, m_last on the 60th, m_user=0, frame_good=1, first beat 6 cycles after the first payload byte.
- Same frame with one payload bit flipped -> 60 beats, m_user=1, frame_bad=1; with CHECK_CRC=0 -> m_user=0.
- gmii_rx_er=1 on payload byte 10 -> full frame output, m_user=1, frame_bad pulse.
- 40-byte frame with correct FCS -> 36 beats, m_user=1 (runt); 3-byte fragment after SFD -> no m_valid, frame_bad=1.
- 1600-byte frame -> m_last on the beat emitted when count reaches 1518, m_user=1, then no output until dv=0; a next frame after a 1-cycle gap is received correctly.
- Preamble with 0x5A in place of 0x55 -> no output and no pulses. Reset asserted mid-payload -> outputs 0 next cycle, and the following frame is good.
